survival_timer: RTL and testbench

Parametrised game-time counter that replaces the fixed three-digit display counter. It owns its own prescaler, counts elapsed game time in NUM_DIGITS BCD digits under a start/stop/clear state machine, and latches the best completed run. It drives one active-low 7-segment pattern per digit for both the current and best time. It sits between the game control FSM (start, collision) and the HEX display pins.

---
 rtl/survival_timer.sv | 152 +++++++++++++++
 tb/tb_survival_timer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/survival_timer.sv
// Game-time counter: prescaled BCD run timer with start/stop/clear control,
// best-run latch and active-low 7-segment decode per digit.
module survival_timer_seg7 (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    unique case (d)
      4'd0:    seg = 7'b100_0000;
      4'd1:    seg = 7'b111_1001;
      4'd2:    seg = 7'b010_0100;
      4'd3:    seg = 7'b011_0000;
      4'd4:    seg = 7'b001_1001;
      4'd5:    seg = 7'b001_0010;
      4'd6:    seg = 7'b000_0010;
      4'd7:    seg = 7'b111_1000;
      4'd8:    seg = 7'b000_0000;
      4'd9:    seg = 7'b001_1000;
      default: seg = 7'b100_0000;
    endcase
  end
endmodule

module survival_timer #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICKS_PER_UNIT = 50_000_000,
  parameter bit SATURATE       = 1'b1
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      collided,
  input  logic                      clear,
  output logic [4*NUM_DIGITS-1:0]   time_bcd,
  output logic [4*NUM_DIGITS-1:0]   best_bcd,
  output logic [7*NUM_DIGITS-1:0]   hex_time,
  output logic [7*NUM_DIGITS-1:0]   hex_best,
  output logic                      running,
  output logic                      overflow,
  output logic                      new_best
);
  localparam int PW = $clog2(TICKS_PER_UNIT);
  localparam int DW = 4*NUM_DIGITS;
  localparam logic [PW-1:0] TMAX = PW'(TICKS_PER_UNIT-1);

  typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   time_q, time_d, best_q, best_d, inc;
  logic            ovf_q, ovf_d, nb_q, nb_d, run_q, run_d, pend_q, pend_d;
  logic            tick, all9;

  // Single-cycle ripple increment; all9 is the carry out of the top digit.
  always_comb begin
    inc  = time_q;
    all9 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (all9) begin
        if (time_q[4*i +: 4] >= 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          all9          = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    best_d  = best_q;
    ovf_d   = ovf_q;
    nb_d    = 1'b0;
    pend_d  = 1'b0;
    tick    = (state_q == RUNNING) && (presc_q == TMAX);

    // Best is judged the cycle after the stop, against the frozen count.
    // Digits never exceed 9, so a plain unsigned compare is MSD-first order.
    if (pend_q && (time_q > best_q)) begin
      best_d = time_q;
      nb_d   = 1'b1;
    end

    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      time_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (start) state_d = RUNNING;
        end
        RUNNING: begin
          if (collided) begin
            state_d = STOPPED;
            pend_d  = 1'b1;
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
              if (all9) begin
                ovf_d  = 1'b1;
                time_d = SATURATE ? time_q : '0;
              end else begin
                time_d = inc;
              end
            end
          end
        end
        default: ;
      endcase
    end
    run_d = (state_d == RUNNING);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      presc_q <= '0;
      time_q  <= '0;
      best_q  <= '0;
      ovf_q   <= 1'b0;
      nb_q    <= 1'b0;
      run_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      best_q  <= best_d;
      ovf_q   <= ovf_d;
      nb_q    <= nb_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
    end
  end

  assign time_bcd = time_q;
  assign best_bcd = best_q;
  assign running  = run_q;
  assign overflow = ovf_q;
  assign new_best = nb_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    survival_timer_seg7 u_time (.d(time_q[4*g +: 4]), .seg(hex_time[7*g +: 7]));
    survival_timer_seg7 u_best (.d(best_q[4*g +: 4]), .seg(hex_best[7*g +: 7]));
  end
endmodule

// File: tb/tb_survival_timer.sv
// Directed bench for survival_timer: two instances (saturating / wrapping)
// share stimulus; expected values are hand-computed constants.
module tb_survival_timer;
  logic clk, resetn, start, collided, clear;
  logic [11:0] s_time, s_best, w_time, w_best;
  logic [20:0] s_hex_t, s_hex_b, w_hex_t, w_hex_b;
  logic s_run, s_ovf, s_nb, w_run, w_ovf, w_nb;
  int nvec = 0, nerr = 0;

  localparam logic [20:0] HEX0 = {3{7'b100_0000}};

  survival_timer #(.NUM_DIGITS(3), .TICKS_PER_UNIT(4), .SATURATE(1'b1)) dut_s (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .collided(collided), .clear(clear),
    .time_bcd(s_time), .best_bcd(s_best), .hex_time(s_hex_t), .hex_best(s_hex_b),
    .running(s_run), .overflow(s_ovf), .new_best(s_nb));

  survival_timer #(.NUM_DIGITS(3), .TICKS_PER_UNIT(4), .SATURATE(1'b0)) dut_w (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .collided(collided), .clear(clear),
    .time_bcd(w_time), .best_bcd(w_best), .hex_time(w_hex_t), .hex_best(w_hex_b),
    .running(w_run), .overflow(w_ovf), .new_best(w_nb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    if (which == 0) start = 1'b1;
    else if (which == 1) collided = 1'b1;
    else clear = 1'b1;
    cyc(1);
    start = 1'b0; collided = 1'b0; clear = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; collided = 1'b0; clear = 1'b0;
    #12;
    chk("rst_time", s_time, 0);      chk("rst_best", s_best, 0);
    chk("rst_hex_t", s_hex_t, HEX0); chk("rst_hex_b", s_hex_b, HEX0);
    chk("rst_run", s_run, 0);        chk("rst_ovf", s_ovf, 0);
    chk("rst_nb", s_nb, 0);
    resetn = 1'b1;
    cyc(1);

    // basic count: start edge N, first increment at N+4
    pulse(0);
    chk("start_run", s_run, 1);  chk("start_time", s_time, 12'h000);
    cyc(3);  chk("pre_tick", s_time, 12'h000);
    cyc(1);  chk("first_tick", s_time, 12'h001);
    cyc(48);
    chk("t013", s_time, 12'h013);
    chk("t013_hex", s_hex_t, {7'b100_0000, 7'b111_1001, 7'b011_0000});
    chk("t013_run", s_run, 1);

    // decimal carry 099 -> 100 in one edge
    cyc(344); chk("t099", s_time, 12'h099);
    for (int i = 0; i < 3; i++) begin
      cyc(1); chk("hold099", s_time, 12'h099);
    end
    cyc(1);   chk("t100", s_time, 12'h100);

    // overflow: saturate vs wrap
    cyc(3596);
    chk("t999_s", s_time, 12'h999); chk("t999_ovf", s_ovf, 0);
    chk("t999_w", w_time, 12'h999);
    cyc(4);
    chk("sat_time", s_time, 12'h999); chk("sat_ovf", s_ovf, 1); chk("sat_run", s_run, 1);
    chk("wrap_time", w_time, 12'h000); chk("wrap_ovf", w_ovf, 1);
    cyc(4);
    chk("sat_hold", s_time, 12'h999); chk("wrap_next", w_time, 12'h001);
    chk("wrap_ovf_sticky", w_ovf, 1);

    pulse(2);
    chk("clr_time", s_time, 0); chk("clr_ovf", s_ovf, 0); chk("clr_run", s_run, 0);
    chk("clr_best", s_best, 0); chk("clr_wovf", w_ovf, 0);

    // first completed run becomes best
    pulse(0); cyc(100);
    chk("run25", s_time, 12'h025);
    pulse(1);
    chk("col_run", s_run, 0); chk("col_nb", s_nb, 0); chk("col_best", s_best, 0);
    chk("col_time", s_time, 12'h025);
    cyc(1);
    chk("best25", s_best, 12'h025); chk("nb_pulse", s_nb, 1);
    chk("best_hex", s_hex_b, {7'b100_0000, 7'b010_0100, 7'b001_0010});
    cyc(1);
    chk("nb_off", s_nb, 0); chk("best25_hold", s_best, 12'h025);

    // start while stopped is ignored
    start = 1'b1; cyc(3); start = 1'b0;
    chk("stop_start_run", s_run, 0); chk("stop_frozen", s_time, 12'h025);

    // lower run does not update best
    pulse(2); pulse(0); cyc(40);
    chk("run10", s_time, 12'h010);
    pulse(1); cyc(1);
    chk("low_nb", s_nb, 0); chk("low_best", s_best, 12'h025);

    // equal run does not update best
    pulse(2); pulse(0); cyc(100);
    chk("run25b", s_time, 12'h025);
    pulse(1); cyc(1);
    chk("eq_nb", s_nb, 0); chk("eq_best", s_best, 12'h025);

    // collision on the tick cycle discards the increment
    pulse(2); pulse(0); cyc(3);
    pulse(1);
    chk("coltick_time", s_time, 12'h000); chk("coltick_run", s_run, 0);
    cyc(4);
    chk("coltick_frozen", s_time, 12'h000); chk("coltick_nb", s_nb, 0);

    // clear wins over start
    clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
    chk("clrstart_run", s_run, 0);
    cyc(5);
    chk("clrstart_time", s_time, 12'h000);

    // asynchronous reset mid-run
    pulse(0); cyc(10);
    chk("pre_rst_time", s_time, 12'h002);
    #3 resetn = 1'b0;
    #1;
    chk("arst_time", s_time, 0); chk("arst_best", s_best, 0);
    chk("arst_run", s_run, 0);   chk("arst_hex_b", s_hex_b, HEX0);
    chk("arst_hex_t", s_hex_t, HEX0);
    resetn = 1'b1;
    cyc(1);
    pulse(0); cyc(4);
    chk("post_rst_time", s_time, 12'h001); chk("post_rst_run", s_run, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
